// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the scalar
// LSU path and the vector unit. It arbitrates in IDLE, issues one latched
// command per ISSUE cycle, and waits in RWAIT for the read data, which is
// routed back to the owner only.
// Optional feature macro: VEC_ARB_TIMEOUT_EN (read-wait timeout abort).
module dmem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_s_req,
    input  logic          i_s_we,
    input  logic [AW-1:0] i_s_addr,
    input  logic [DW-1:0] i_s_wdata,
    output logic          o_s_gnt,
    output logic          o_s_rvalid,
    output logic [DW-1:0] o_s_rdata,
    input  logic          i_v_req,
    input  logic          i_v_we,
    input  logic [AW-1:0] i_v_addr,
    input  logic [DW-1:0] i_v_wdata,
    input  logic          i_v_lock,
    output logic          o_v_gnt,
    output logic          o_v_rvalid,
    output logic [DW-1:0] o_v_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic          o_mem_re,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_rvalid,
    output logic          o_busy,
    output logic          o_timeout_err
);

    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_nxt;
    logic          win;
    logic          win_v;
    logic          owner_v;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          tmo_fire;
    logic          issue;
    logic          rdone;
    logic [DW-1:0] rdata_sel;

    // Arbitration, next-state selection and vector starvation accounting
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve;
        win        = 1'b0;
        win_v      = 1'b0;
        case (state)
            IDLE: begin
                if (i_v_lock) begin
                    // Port reserved for the vector unit; scalar never wins here
                    win   = i_v_req;
                    win_v = i_v_req;
                end else if (i_s_req && i_v_req && (starve == STARVE_LIM)) begin
                    win   = 1'b1;
                    win_v = 1'b1;
                end else if (i_s_req) begin
                    win   = 1'b1;
                end else if (i_v_req) begin
                    win   = 1'b1;
                    win_v = 1'b1;
                end
                if (win) begin
                    state_nxt = ISSUE;
                end
                if (win_v) begin
                    starve_nxt = '0;
                end else if (i_v_req && (starve != STARVE_LIM)) begin
                    starve_nxt = starve + SW'(1);
                end
            end
            ISSUE: begin
                state_nxt = we_q ? IDLE : RWAIT;
            end
            RWAIT: begin
                if (i_mem_rvalid || tmo_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, starve counter and latched command of the winning requester
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            starve  <= '0;
            owner_v <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
            if (win) begin
                owner_v <= win_v;
                we_q    <= win_v ? i_v_we    : i_s_we;
                addr_q  <= win_v ? i_v_addr  : i_s_addr;
                wdata_q <= win_v ? i_v_wdata : i_s_wdata;
            end
        end
    end

`ifdef VEC_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;

    // Read-wait cycle counter, restarted each time a read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if ((state == RWAIT) && (tmo_cnt != TMO_LAST)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Real data arriving in the last wait cycle takes precedence over the abort
    assign tmo_fire      = (state == RWAIT) && !i_mem_rvalid && (tmo_cnt == TMO_LAST);
    assign o_timeout_err = tmo_fire;
`else
    // Without the abort path the wait is unbounded; TIMEOUT has no effect
    assign tmo_fire      = 1'b0 && (TIMEOUT != 0);
    assign o_timeout_err = 1'b0;
`endif

    // Memory command: valid only in ISSUE, address held from the latch
    assign issue       = (state == ISSUE);
    assign o_mem_addr  = addr_q;
    assign o_mem_we    = issue && we_q;
    assign o_mem_re    = issue && !we_q;
    assign o_mem_wdata = (issue && we_q) ? wdata_q : '0;
    assign o_s_gnt     = issue && !owner_v;
    assign o_v_gnt     = issue && owner_v;

    // Read return steered to the owner in the completing RWAIT cycle
    assign rdone      = (state == RWAIT) && (i_mem_rvalid || tmo_fire);
    assign rdata_sel  = i_mem_rvalid ? i_mem_rdata : '0;
    assign o_s_rvalid = rdone && !owner_v;
    assign o_v_rvalid = rdone && owner_v;
    assign o_s_rdata  = o_s_rvalid ? rdata_sel : '0;
    assign o_v_rdata  = o_v_rvalid ? rdata_sel : '0;

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected grant and
// read-return events (with their cycle), a monitor pops and compares them.
module tb_dmem_port_arbiter;

    localparam int K_SGNT = 0;
    localparam int K_VGNT = 1;
    localparam int K_SRV  = 2;
    localparam int K_VRV  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_req, s_we, v_req, v_we, v_lock, mem_rvalid;
    logic [31:0] s_addr, s_wdata, v_addr, v_wdata, mem_rdata;
    logic        s_gnt, s_rvalid, v_gnt, v_rvalid, mem_we, mem_re, busy, tmo_err;
    logic [31:0] s_rdata, v_rdata, mem_addr, mem_wdata;

    typedef struct {
        int          kind;
        int          cyc;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .i_s_req(s_req), .i_s_we(s_we), .i_s_addr(s_addr), .i_s_wdata(s_wdata),
        .o_s_gnt(s_gnt), .o_s_rvalid(s_rvalid), .o_s_rdata(s_rdata),
        .i_v_req(v_req), .i_v_we(v_we), .i_v_addr(v_addr), .i_v_wdata(v_wdata),
        .i_v_lock(v_lock),
        .o_v_gnt(v_gnt), .o_v_rvalid(v_rvalid), .o_v_rdata(v_rdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_re(mem_re),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_rvalid(mem_rvalid),
        .o_busy(busy), .o_timeout_err(tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] w, input logic [31:0] r);
        exp_t e;
        e.kind = kind; e.cyc = c; e.we = we; e.re = re;
        e.addr = a; e.wdata = w; e.rdata = r;
        q.push_back(e);
    endtask

    // Monitor: every grant or read return must match the oldest expectation
    always @(negedge clk) begin
        int   nhit;
        int   kind;
        logic ok;
        exp_t e;
        nhit = int'(s_gnt) + int'(v_gnt) + int'(s_rvalid) + int'(v_rvalid);
        if (nhit != 0) begin
            n_tests++;
            kind = s_gnt ? K_SGNT : v_gnt ? K_VGNT : s_rvalid ? K_SRV : K_VRV;
            if (nhit > 1) begin
                n_fail++;
                $display("FAIL sb_multi: %0d events at cycle %0d, required 1", nhit, cyc);
            end else if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: event kind %0d at cycle %0d, none required", kind, cyc);
            end else begin
                e = q.pop_front();
                ok = (kind == e.kind) && (cyc == e.cyc);
                if (kind <= K_VGNT)
                    ok = ok && (mem_we === e.we) && (mem_re === e.re) &&
                         (mem_addr === e.addr) && (mem_wdata === e.wdata);
                else if (kind == K_SRV)
                    ok = ok && (s_rdata === e.rdata) && (v_rdata === 32'h0);
                else
                    ok = ok && (v_rdata === e.rdata) && (s_rdata === 32'h0);
                if (!ok) begin
                    n_fail++;
                    $display("FAIL sb_event: got kind %0d cyc %0d we %0b re %0b addr %08h wd %08h srd %08h vrd %08h; required kind %0d cyc %0d we %0b re %0b addr %08h wd %08h rd %08h",
                             kind, cyc, mem_we, mem_re, mem_addr, mem_wdata, s_rdata, v_rdata,
                             e.kind, e.cyc, e.we, e.re, e.addr, e.wdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
        v_req = 0; v_we = 0; v_addr = 0; v_wdata = 0; v_lock = 0;
        mem_rvalid = 0; mem_rdata = 0;
        step();
        step();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_strobes", {28'h0, mem_we, mem_re, s_gnt, v_gnt}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", s_rdata | v_rdata, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Scalar write
        s_req = 1; s_we = 1; s_addr = 32'h100; s_wdata = 32'hDEADBEEF;
        push(K_SGNT, cyc + 1, 1, 0, 32'h100, 32'hDEADBEEF, 0);
        step();
        s_req = 0;
        step();
        @(negedge clk);
        chk("swr_busy_after", 32'(busy), 32'h0);
        step();

        // Vector read, data three cycles after issue; rvalid during ISSUE ignored
        v_req = 1; v_we = 0; v_addr = 32'h200; v_wdata = 32'h55;
        push(K_VGNT, cyc + 1, 0, 1, 32'h200, 32'h0, 0);
        push(K_VRV, cyc + 4, 0, 0, 0, 0, 32'h12345678);
        step();
        v_req = 0; mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
        step();
        mem_rvalid = 0;
        @(negedge clk);
        chk("vrd_wait_addr", mem_addr, 32'h200);
        chk("vrd_wait_strobes", {30'h0, mem_we, mem_re}, 32'h0);
        chk("vrd_wait_busy", 32'(busy), 32'h1);
        step();
        step();
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        step();
        mem_rvalid = 0;
        @(negedge clk);
        chk("vrd_busy_after", 32'(busy), 32'h0);
        step();

        // Scalar read with data on the earliest possible cycle
        s_req = 1; s_we = 0; s_addr = 32'h104; s_wdata = 32'h0;
        push(K_SGNT, cyc + 1, 0, 1, 32'h104, 32'h0, 0);
        push(K_SRV, cyc + 2, 0, 0, 0, 0, 32'hCAFEF00D);
        step();
        s_req = 0;
        step();
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_rvalid = 0;
        step();

        // Contention: scalar wins 8 times, vector the 9th, then counter is clear
        s_req = 1; s_we = 1; v_req = 1; v_we = 1; v_addr = 32'h400; v_wdata = 32'hA0A0A0A0;
        for (int k = 0; k < 8; k++) begin
            s_addr = 32'h300 + 32'(4 * k);
            s_wdata = 32'h1000 + 32'(k);
            push(K_SGNT, cyc + 1, 1, 0, s_addr, s_wdata, 0);
            step();
            step();
        end
        push(K_VGNT, cyc + 1, 1, 0, 32'h400, 32'hA0A0A0A0, 0);
        step();
        v_addr = 32'h404; v_wdata = 32'hB0B0B0B0; s_addr = 32'h320; s_wdata = 32'h2000;
        step();
        push(K_SGNT, cyc + 1, 1, 0, 32'h320, 32'h2000, 0);
        step();
        s_req = 0;
        step();
        push(K_VGNT, cyc + 1, 1, 0, 32'h404, 32'hB0B0B0B0, 0);
        step();
        v_req = 0;
        step();

        // Lock: vector wins despite scalar, then scalar is held off while locked
        v_lock = 1; v_req = 1; v_we = 1; v_addr = 32'h600; v_wdata = 32'h66;
        s_req = 1; s_we = 1; s_addr = 32'h500; s_wdata = 32'h55;
        push(K_VGNT, cyc + 1, 1, 0, 32'h600, 32'h66, 0);
        step();
        v_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("lock_busy", 32'(busy), 32'h0);
        end
        step();
        v_lock = 0;
        push(K_SGNT, cyc + 1, 1, 0, 32'h500, 32'h55, 0);
        step();
        s_req = 0;
        step();

        // Reset during RWAIT; a late rvalid must be dropped
        s_req = 1; s_we = 0; s_addr = 32'h700;
        push(K_SGNT, cyc + 1, 0, 1, 32'h700, 32'h0, 0);
        step();
        s_req = 0;
        step();
        rst = 1;
        step();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("postrst_rvalid", {30'h0, s_rvalid, v_rvalid}, 32'h0);
            chk("postrst_rdata", s_rdata | v_rdata, 32'h0);
            chk("postrst_busy", 32'(busy), 32'h0);
            chk("postrst_mem_addr", mem_addr, 32'h0);
            step();
        end
        mem_rvalid = 0;
        step();
        step();

        @(negedge clk);
        chk("sb_pending", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
